// File: rtl/sram_row_access_ctrl_if.sv
// Bundles the row-access controller's control, SRAM and filter-side handshakes.
// master = controller view, slave = environment (SRAM/filter/sequencer) view.
interface sram_row_access_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_BITS   = 13
);
  logic                  start;
  logic [CNT_BITS-1:0]   image_width;
  logic                  busy;
  logic                  done;
  logic                  addr_clear;
  logic                  addr_mode;
  logic                  addr_enable;
  logic                  sram_read_en;
  logic                  sram_write_en;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;
  logic                  sram_ack;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;

  modport master (
    input  start, image_width, sram_rdata, sram_ack, rd_ready, wr_data, wr_valid,
    output busy, done, addr_clear, addr_mode, addr_enable, sram_read_en,
           sram_write_en, sram_wdata, rd_data, rd_valid, wr_ready
  );

  modport slave (
    output start, image_width, sram_rdata, sram_ack, rd_ready, wr_data, wr_valid,
    input  busy, done, addr_clear, addr_mode, addr_enable, sram_read_en,
           sram_write_en, sram_wdata, rd_data, rd_valid, wr_ready
  );
endinterface

// File: rtl/sram_row_access_ctrl.sv
// Row access sequencer: reads one image row from the row cache, streams it to
// the filter, then writes width-1 filter results to the output region while
// steering the external address calculator (clear / mode / enable).
module sram_row_access_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_BITS   = 13
) (
  input logic                   clk,
  input logic                   rst,
  sram_row_access_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RD_REQ,
    RD_HOLD,
    WR_GET,
    WR_REQ,
    FIN
  } state_t;

  state_t                state;
  logic [CNT_BITS-1:0]   wlat;
  logic [CNT_BITS-1:0]   rcnt;
  logic [CNT_BITS-1:0]   wcnt;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  assign bus.rd_data    = rd_data_q;
  assign bus.sram_wdata = wdata_q;

  // addr_enable is the only combinational output so that each pulse lands in
  // the ack cycle itself rather than one cycle after it.
  assign bus.addr_enable = ((state == RD_REQ) || (state == WR_REQ)) && bus.sram_ack;

  // Row sequencing FSM with registered control and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      wlat              <= '0;
      rcnt              <= '0;
      wcnt              <= '0;
      rd_data_q         <= '0;
      wdata_q           <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.addr_clear    <= 1'b0;
      bus.addr_mode     <= 1'b0;
      bus.sram_read_en  <= 1'b0;
      bus.sram_write_en <= 1'b0;
      bus.rd_valid      <= 1'b0;
      bus.wr_ready      <= 1'b0;
    end else begin
      bus.done       <= 1'b0;
      bus.addr_clear <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            wlat     <= bus.image_width;
            rcnt     <= '0;
            wcnt     <= '0;
            bus.busy <= 1'b1;
            if (bus.image_width == '0) begin
              state    <= FIN;
              bus.done <= 1'b1;
            end else begin
              state          <= CLR;
              bus.addr_clear <= 1'b1;
            end
          end
        end
        CLR: begin
          rcnt             <= '0;
          wcnt             <= '0;
          bus.addr_mode    <= 1'b1;
          bus.sram_read_en <= 1'b1;
          state            <= RD_REQ;
        end
        RD_REQ: begin
          if (bus.sram_ack) begin
            bus.sram_read_en <= 1'b0;
            rd_data_q        <= bus.sram_rdata;
            bus.rd_valid     <= 1'b1;
            rcnt             <= rcnt + CNT_BITS'(1);
            state            <= RD_HOLD;
          end
        end
        RD_HOLD: begin
          if (bus.rd_ready) begin
            bus.rd_valid <= 1'b0;
            if (rcnt < wlat) begin
              bus.addr_mode    <= 1'b1;
              bus.sram_read_en <= 1'b1;
              state            <= RD_REQ;
            end else if (wlat > CNT_BITS'(1)) begin
              bus.wr_ready <= 1'b1;
              state        <= WR_GET;
            end else begin
              bus.done <= 1'b1;
              state    <= FIN;
            end
          end
        end
        WR_GET: begin
          if (bus.wr_valid && bus.wr_ready) begin
            bus.wr_ready      <= 1'b0;
            wdata_q           <= bus.wr_data;
            bus.addr_mode     <= 1'b0;
            bus.sram_write_en <= 1'b1;
            state             <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (bus.sram_ack) begin
            bus.sram_write_en <= 1'b0;
            wcnt              <= wcnt + CNT_BITS'(1);
            if ((wcnt + CNT_BITS'(1)) == (wlat - CNT_BITS'(1))) begin
              bus.done <= 1'b1;
              state    <= FIN;
            end else begin
              bus.wr_ready <= 1'b1;
              state        <= WR_GET;
            end
          end
        end
        FIN: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_row_access_ctrl.sv
// Self-checking bench for sram_row_access_ctrl: random SRAM latencies, random
// filter-side handshakes, and a queue-based reference of the row transfer.
module tb_sram_row_access_ctrl;
  localparam int DW = 16;
  localparam int CB = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_row_access_ctrl_if #(.DATA_WIDTH(DW), .CNT_BITS(CB)) bus ();
  sram_row_access_ctrl #(.DATA_WIDTH(DW), .CNT_BITS(CB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observations gathered by run_row for the calling test to judge.
  logic [DW-1:0] exp_rd[$];
  logic [DW-1:0] got_rd[$];
  logic [DW-1:0] sent_wr[$];
  logic [DW-1:0] got_wr[$];
  int en_rd, en_wr, clr_cnt, done_cnt, done_cycle, timeout, aborted, post_abort_done;
  int v_both, v_drop, v_mode, v_en, v_wdata, v_rdhold, v_overlap;
  int req_min, req_max, n_req, stall_cnt;
  logic busy_end;
  logic [40:0] outs_at_rst;

  function automatic logic [40:0] outs();
    return {bus.busy, bus.done, bus.addr_clear, bus.addr_mode, bus.addr_enable,
            bus.sram_read_en, bus.sram_write_en, bus.sram_wdata, bus.rd_data,
            bus.rd_valid, bus.wr_ready};
  endfunction

  function automatic bit same_q(input logic [DW-1:0] a[$], input logic [DW-1:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int exp_writes(input int w);
    return (w > 1) ? w - 1 : 0;
  endfunction

  function automatic int viol_sum();
    return v_both + v_drop + v_mode + v_en + v_wdata + v_rdhold + v_overlap;
  endfunction

  task automatic set_idle();
    bus.start = 1'b0; bus.image_width = '0; bus.sram_ack = 1'b0; bus.sram_rdata = '0;
    bus.rd_ready = 1'b0; bus.wr_data = '0; bus.wr_valid = 1'b0;
  endtask

  // Plays SRAM, filter consumer/producer and sequencer for one row start.
  task automatic run_row(input int w, input int dmin, input int dmax, input int rdy_pct,
                         input int vld_pct, input bit spur, input int hold_word,
                         input int hold_cyc, input int restart_cyc, input int restart_w,
                         input int abort_wr);
    int age, dly, len, tail, wr_seen;
    bit prev_req, prev_rd, prev_wr, prev_ack, prev_rv, prev_rr, have_pend;
    bit ack, rdy, vld, req_rd, req_wr, stall, seen_done;
    logic req_mode;
    logic [DW-1:0] req_wd, prev_rdo, pend, d;
    exp_rd.delete(); got_rd.delete(); sent_wr.delete(); got_wr.delete();
    en_rd = 0; en_wr = 0; clr_cnt = 0; done_cnt = 0; done_cycle = -1; timeout = 0;
    aborted = 0; post_abort_done = 0; v_both = 0; v_drop = 0; v_mode = 0; v_en = 0;
    v_wdata = 0; v_rdhold = 0; v_overlap = 0; req_min = 1000; req_max = 0; n_req = 0;
    stall_cnt = 0; outs_at_rst = '1;
    age = 0; dly = 0; len = 0; tail = 0; wr_seen = 0; prev_req = 0; prev_rd = 0;
    prev_wr = 0; prev_ack = 0; prev_rv = 0; prev_rr = 0; have_pend = 0; seen_done = 0;
    req_mode = 1'b0; req_wd = '0; prev_rdo = '0; pend = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        bus.start = 1'b1; bus.image_width = CB'(w);
      end else if (cyc == restart_cyc) begin
        bus.start = 1'b1; bus.image_width = CB'(restart_w);
      end else begin
        bus.start = 1'b0; bus.image_width = CB'($urandom);
      end
      // SRAM side
      req_rd = bus.sram_read_en;
      req_wr = bus.sram_write_en;
      if (req_rd && req_wr) v_both++;
      if (prev_req && !prev_ack && !((prev_rd && req_rd) || (prev_wr && req_wr))) v_drop++;
      if (prev_req && prev_ack && (req_rd || req_wr)) v_drop++;
      if ((req_rd && bus.addr_mode !== 1'b1) || (req_wr && bus.addr_mode !== 1'b0)) v_mode++;
      ack = 1'b0;
      if (req_rd || req_wr) begin
        if (!prev_req || prev_ack) begin
          age = 0; len = 0; dly = int'($urandom_range(dmax, dmin));
          req_mode = bus.addr_mode; req_wd = bus.sram_wdata; n_req++;
          if (req_wr) wr_seen++;
          if (abort_wr > 0 && req_wr && wr_seen == abort_wr) begin
            bus.sram_ack = 1'b0;
            rst = 1'b1;
            #1;
            outs_at_rst = outs();
            aborted = 1;
            @(negedge clk);
            rst = 1'b0;
            set_idle();
            for (int k = 0; k < 10; k++) begin
              @(negedge clk);
              if (bus.done === 1'b1) post_abort_done++;
            end
            break;
          end
        end else begin
          if (bus.addr_mode !== req_mode) v_mode++;
          if (req_wr && bus.sram_wdata !== req_wd) v_wdata++;
        end
        len++;
        ack = (age >= dly);
        age++;
        if (ack) begin
          if (len < req_min) req_min = len;
          if (len > req_max) req_max = len;
          if (req_rd) begin
            d = DW'($urandom); bus.sram_rdata = d; exp_rd.push_back(d);
          end else begin
            got_wr.push_back(bus.sram_wdata); bus.sram_rdata = DW'($urandom);
          end
        end else begin
          bus.sram_rdata = DW'($urandom);
        end
      end else begin
        ack = spur && ($urandom_range(3, 0) == 0);
        bus.sram_rdata = DW'($urandom);
      end
      bus.sram_ack = ack;
      // Row consumer
      if (prev_rv && !prev_rr)
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== prev_rdo) v_rdhold++;
      if (bus.rd_valid && (req_rd || req_wr)) v_overlap++;
      stall = bus.rd_valid && hold_word > 0 && got_rd.size() == hold_word - 1 &&
              stall_cnt < hold_cyc;
      rdy = !stall && (int'($urandom_range(99, 0)) < rdy_pct);
      if (stall) stall_cnt++;
      bus.rd_ready = rdy;
      if (bus.rd_valid && rdy) got_rd.push_back(bus.rd_data);
      prev_rv = bus.rd_valid; prev_rr = rdy; prev_rdo = bus.rd_data;
      // Result producer
      if (!have_pend) begin pend = DW'($urandom); have_pend = 1; end
      vld = int'($urandom_range(99, 0)) < vld_pct;
      bus.wr_valid = vld;
      bus.wr_data = vld ? pend : DW'($urandom);
      if (vld && bus.wr_ready) begin sent_wr.push_back(pend); have_pend = 0; end
      #1;
      if (bus.addr_enable !== ((req_rd || req_wr) && ack)) v_en++;
      if (bus.addr_enable === 1'b1) begin
        if (bus.addr_mode) en_rd++; else en_wr++;
      end
      if (bus.addr_clear === 1'b1) clr_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (!seen_done) done_cycle = cyc;
        seen_done = 1;
      end
      prev_req = req_rd || req_wr; prev_rd = req_rd; prev_wr = req_wr; prev_ack = ack;
      if (seen_done) begin
        tail++;
        if (tail > 4) break;
      end
    end
    if (!seen_done && aborted == 0) timeout = 1;
    busy_end = bus.busy;
    set_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    repeat (2) @(negedge clk);
    n_checks++;
    if (outs() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", outs());
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs() !== '0) begin
      n_fail++; $display("FAIL post_reset_idle: got %h want 0", outs());
    end
  endtask

  task automatic test_basic();
    run_row(4, 0, 0, 100, 100, 1'b0, 0, 0, -1, 0, 0);
    n_checks++;
    if (timeout !== 0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL basic_done: got %0d dones timeout %0d want 1/0", done_cnt, timeout);
    end
    n_checks++;
    if (done_cycle !== 16) begin
      n_fail++; $display("FAIL basic_latency: got done at %0d want 16", done_cycle);
    end
    n_checks++;
    if (!same_q(got_rd, exp_rd) || got_rd.size() !== 4) begin
      n_fail++; $display("FAIL basic_reads: got %0d words want 4 matching", got_rd.size());
    end
    n_checks++;
    if (!same_q(got_wr, sent_wr) || got_wr.size() !== 3) begin
      n_fail++; $display("FAIL basic_writes: got %0d writes want 3 matching", got_wr.size());
    end
    n_checks++;
    if (en_rd !== 4 || en_wr !== 3 || clr_cnt !== 1) begin
      n_fail++; $display("FAIL basic_addr: got en %0d/%0d clr %0d want 4/3/1", en_rd, en_wr, clr_cnt);
    end
    n_checks++;
    if (busy_end !== 1'b0 || viol_sum() !== 0) begin
      n_fail++; $display("FAIL basic_protocol: got busy %b viol %0d want 0/0", busy_end, viol_sum());
    end
  endtask

  task automatic test_ack_delay();
    run_row(3, 2, 2, 100, 100, 1'b1, 0, 0, -1, 0, 0);
    n_checks++;
    if (req_min !== 3 || req_max !== 3 || n_req !== 5) begin
      n_fail++; $display("FAIL delay_req_len: got min %0d max %0d n %0d want 3/3/5", req_min, req_max, n_req);
    end
    n_checks++;
    if (v_mode !== 0 || v_wdata !== 0 || v_en !== 0 || v_drop !== 0) begin
      n_fail++; $display("FAIL delay_stability: got mode %0d wdata %0d en %0d drop %0d want 0", v_mode, v_wdata, v_en, v_drop);
    end
    n_checks++;
    if (!same_q(got_rd, exp_rd) || !same_q(got_wr, sent_wr) || got_wr.size() !== 2) begin
      n_fail++; $display("FAIL delay_data: got %0d reads %0d writes want 3/2 matching", got_rd.size(), got_wr.size());
    end
    n_checks++;
    if (en_rd !== 3 || en_wr !== 2 || done_cnt !== 1) begin
      n_fail++; $display("FAIL delay_counts: got en %0d/%0d done %0d want 3/2/1", en_rd, en_wr, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    run_row(4, 0, 1, 100, 100, 1'b0, 2, 5, -1, 0, 0);
    n_checks++;
    if (stall_cnt !== 5 || v_rdhold !== 0 || v_overlap !== 0) begin
      n_fail++; $display("FAIL bp_hold: got stalls %0d hold %0d overlap %0d want 5/0/0", stall_cnt, v_rdhold, v_overlap);
    end
    n_checks++;
    if (!same_q(got_rd, exp_rd) || got_rd.size() !== 4 || en_rd !== 4) begin
      n_fail++; $display("FAIL bp_reads: got %0d words en %0d want 4/4", got_rd.size(), en_rd);
    end
    n_checks++;
    if (done_cnt !== 1 || got_wr.size() !== 3) begin
      n_fail++; $display("FAIL bp_finish: got done %0d writes %0d want 1/3", done_cnt, got_wr.size());
    end
  endtask

  task automatic test_edge_widths();
    run_row(1, 0, 0, 100, 100, 1'b0, 0, 0, -1, 0, 0);
    n_checks++;
    if (got_rd.size() !== 1 || !same_q(got_rd, exp_rd) || got_wr.size() !== 0 || sent_wr.size() !== 0) begin
      n_fail++; $display("FAIL w1_transfers: got %0d reads %0d writes want 1/0", got_rd.size(), got_wr.size());
    end
    n_checks++;
    if (done_cnt !== 1 || done_cycle !== 4 || en_rd !== 1 || en_wr !== 0) begin
      n_fail++; $display("FAIL w1_done: got done %0d at %0d en %0d/%0d want 1 at 4 en 1/0", done_cnt, done_cycle, en_rd, en_wr);
    end
    run_row(0, 0, 0, 100, 100, 1'b1, 0, 0, -1, 0, 0);
    n_checks++;
    if (n_req !== 0 || clr_cnt !== 0 || en_rd + en_wr !== 0) begin
      n_fail++; $display("FAIL w0_no_access: got req %0d clr %0d en %0d want 0", n_req, clr_cnt, en_rd + en_wr);
    end
    n_checks++;
    if (done_cnt !== 1 || done_cycle !== 1 || busy_end !== 1'b0) begin
      n_fail++; $display("FAIL w0_done: got done %0d at %0d busy %b want 1 at 1 busy 0", done_cnt, done_cycle, busy_end);
    end
  endtask

  task automatic test_reset_mid_op();
    run_row(5, 0, 2, 100, 100, 1'b0, 0, 0, -1, 0, 2);
    n_checks++;
    if (aborted !== 1 || outs_at_rst !== '0) begin
      n_fail++; $display("FAIL rst_outputs: got aborted %0d outs %h want 1/0", aborted, outs_at_rst);
    end
    n_checks++;
    if (done_cnt !== 0 || post_abort_done !== 0 || got_wr.size() !== 1 || en_rd !== 5) begin
      n_fail++; $display("FAIL rst_no_done: got done %0d/%0d writes %0d en_rd %0d want 0/0/1/5", done_cnt, post_abort_done, got_wr.size(), en_rd);
    end
    run_row(2, 0, 2, 100, 100, 1'b0, 0, 0, -1, 0, 0);
    n_checks++;
    if (done_cnt !== 1 || got_rd.size() !== 2 || !same_q(got_rd, exp_rd) ||
        got_wr.size() !== 1 || !same_q(got_wr, sent_wr) || viol_sum() !== 0) begin
      n_fail++; $display("FAIL rst_recover: got done %0d reads %0d writes %0d viol %0d want 1/2/1/0", done_cnt, got_rd.size(), got_wr.size(), viol_sum());
    end
  endtask

  task automatic test_restart_ignored();
    run_row(3, 0, 1, 100, 100, 1'b0, 0, 0, 5, 7, 0);
    n_checks++;
    if (done_cnt !== 1 || got_rd.size() !== 3 || got_wr.size() !== 2) begin
      n_fail++; $display("FAIL restart_counts: got done %0d reads %0d writes %0d want 1/3/2", done_cnt, got_rd.size(), got_wr.size());
    end
    n_checks++;
    if (en_rd !== 3 || en_wr !== 2 || clr_cnt !== 1) begin
      n_fail++; $display("FAIL restart_addr: got en %0d/%0d clr %0d want 3/2/1", en_rd, en_wr, clr_cnt);
    end
  endtask

  task automatic test_random();
    int w, dmax, rp, vp, ew;
    for (int r = 0; r < 12; r++) begin
      w = int'($urandom_range(9, 0));
      dmax = int'($urandom_range(3, 0));
      rp = int'($urandom_range(100, 30));
      vp = int'($urandom_range(100, 30));
      ew = exp_writes(w);
      run_row(w, 0, dmax, rp, vp, 1'b1, 0, 0, -1, 0, 0);
      n_checks++;
      if (timeout !== 0 || done_cnt !== 1 || busy_end !== 1'b0) begin
        n_fail++; $display("FAIL rand_done w=%0d: got done %0d timeout %0d busy %b want 1/0/0", w, done_cnt, timeout, busy_end);
      end
      n_checks++;
      if (!same_q(got_rd, exp_rd) || got_rd.size() !== w) begin
        n_fail++; $display("FAIL rand_reads w=%0d: got %0d words want %0d matching", w, got_rd.size(), w);
      end
      n_checks++;
      if (!same_q(got_wr, sent_wr) || got_wr.size() !== ew) begin
        n_fail++; $display("FAIL rand_writes w=%0d: got %0d writes want %0d matching", w, got_wr.size(), ew);
      end
      n_checks++;
      if (en_rd !== w || en_wr !== ew || clr_cnt !== ((w > 0) ? 1 : 0)) begin
        n_fail++; $display("FAIL rand_addr w=%0d: got en %0d/%0d clr %0d want %0d/%0d", w, en_rd, en_wr, clr_cnt, w, ew);
      end
      n_checks++;
      if (viol_sum() !== 0) begin
        n_fail++; $display("FAIL rand_protocol w=%0d: got both %0d drop %0d mode %0d en %0d wdata %0d hold %0d overlap %0d want 0",
                           w, v_both, v_drop, v_mode, v_en, v_wdata, v_rdhold, v_overlap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_delay();
    test_backpressure();
    test_edge_widths();
    test_reset_mid_op();
    test_restart_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
